// File: rtl/demux1to2_buf.sv
// demux1to2_buf: buffered 1-to-2 demultiplexer, one FIFO per destination channel
// Ports: clk, rst (sync, active-high); in_valid/in_ready/switch/in_data producer side
// (switch=1 -> channel 1, switch=0 -> channel 2); outN_valid/outN_ready/outN per channel.
// Optional macro DEMUX_COUNT_EN adds 8-bit delivered-word counters out1_count/out2_count.
module demux1to2_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             switch,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       out1_count,
  output logic [7:0]       out2_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] full, empty, push, pop, rdy;
  logic [WIDTH-1:0] head [2];
  assign rdy = {out2_ready, out1_ready};
  assign in_ready = switch ? !full[0] : !full[1];
  assign push[0] = in_valid && switch && !full[0];
  assign push[1] = in_valid && !switch && !full[1];
  assign out1_valid = !empty[0];
  assign out2_valid = !empty[1];
  assign out1 = head[0];
  assign out2 = head[1];
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign full[c] = cnt == (AW+1)'(DEPTH);
    assign empty[c] = cnt == '0;
    assign pop[c] = !empty[c] && rdy[c];
    assign head[c] = mem[rp];
    always_ff @(posedge clk) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[c]) begin
          mem[wp] <= in_data;
          wp <= wp + AW'(1);
        end
        if (pop[c]) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      end
    end
  end
`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_count <= '0;
      out2_count <= '0;
    end else begin
      if (pop[0]) out1_count <= out1_count + 8'd1;
      if (pop[1]) out2_count <= out2_count + 8'd1;
    end
  end
`endif
endmodule
